top_fdct_mul_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 16s x 13s -> 29s multiplier between NUM_REQ fdct requesters.

---
 rtl/top_fdct_mul_arb_pkg.sv | 21 ++
 rtl/top_fdct_mul_arbiter_if.sv | 27 ++
 rtl/top_fdct_mul_arb_rr.sv | 29 ++
 rtl/top_fdct_mul_mul_16s_13s_29_1_1.sv | 10 +
 rtl/top_fdct_mul_arbiter.sv | 120 ++++++++++++
 tb/tb_top_fdct_mul_arbiter.sv | 185 ++++++++++++++++++
 6 files changed

// File: rtl/top_fdct_mul_arb_pkg.sv
// Shared sizes and types for the fdct multiplier arbiter.
package top_fdct_mul_arb_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ);
  localparam int unsigned DIN0_WIDTH = 16;
  localparam int unsigned DIN1_WIDTH = 13;
  localparam int unsigned DOUT_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  typedef logic [NUM_REQ-1:0]  grant_t;
  typedef logic [ID_WIDTH-1:0] id_t;

  // Round-robin successor of a requester id, wrapping NUM_REQ-1 -> 0.
  function automatic id_t next_ptr(input id_t id);
    if (int'(id) == NUM_REQ - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/top_fdct_mul_arbiter_if.sv
// Requester-side and product-side handshake bundle of the multiplier arbiter.
interface top_fdct_mul_arbiter_if
  import top_fdct_mul_arb_pkg::*;
();

  grant_t                                req_valid;
  grant_t                                req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0]         req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0]         req_din1;
  logic                                  out_valid;
  logic                                  out_ready;
  logic signed [DOUT_WIDTH-1:0]          out_dout;
  id_t                                   out_id;

  // Requesters plus product consumer.
  modport master (
    output req_valid, req_din0, req_din1, out_ready,
    input  req_ready, out_valid, out_dout, out_id
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_din0, req_din1, out_ready,
    output req_ready, out_valid, out_dout, out_id
  );

endinterface

// File: rtl/top_fdct_mul_arb_rr.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, with wrap.
module top_fdct_mul_arb_rr
  import top_fdct_mul_arb_pkg::*;
(
  input  grant_t req_valid_i,
  input  id_t    rr_ptr_i,
  output grant_t grant_o,
  output id_t    grant_id_o,
  output logic   any_o
);

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    id_t idx;
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    idx        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = id_t'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (!any_o && req_valid_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = idx;
      end
    end
  end

endmodule

// File: rtl/top_fdct_mul_mul_16s_13s_29_1_1.sv
// Combinational 16s x 13s -> 29s multiplier shared by the fdct datapaths.
module top_fdct_mul_mul_16s_13s_29_1_1 (
  input  logic signed [15:0] din0,
  input  logic signed [12:0] din1,
  output logic signed [28:0] dout
);

  assign dout = din0 * din1;

endmodule

// File: rtl/top_fdct_mul_arbiter.sv
// Round-robin arbiter feeding one shared multiplier through a two-stage pipeline.
module top_fdct_mul_arbiter
  import top_fdct_mul_arb_pkg::*;
(
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  top_fdct_mul_arbiter_if.slave  bus,
  output logic                   busy
);

  id_t                          rr_ptr_q, rr_ptr_d;
  logic                         s1_valid_q, s1_valid_d;
  logic signed [DIN0_WIDTH-1:0] s1_a_q, s1_a_d;
  logic signed [DIN1_WIDTH-1:0] s1_b_q, s1_b_d;
  id_t                          s1_id_q, s1_id_d;
  logic                         out_valid_q, out_valid_d;
  logic signed [DOUT_WIDTH-1:0] out_dout_q, out_dout_d;
  id_t                          out_id_q, out_id_d;

  grant_t                       grant;
  id_t                          grant_id;
  logic                         grant_any;
  logic                         s1_en;
  logic                         s2_en;
  logic                         accept;
  grant_t                       ready;
  logic signed [DOUT_WIDTH-1:0] mul_dout;
  logic [DIN0_WIDTH-1:0]        din0_arr [NUM_REQ];
  logic [DIN1_WIDTH-1:0]        din1_arr [NUM_REQ];

  top_fdct_mul_arb_rr u_rr (
    .req_valid_i (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_id_o  (grant_id),
    .any_o       (grant_any)
  );

  top_fdct_mul_mul_16s_13s_29_1_1 u_mul (
    .din0 (s1_a_q),
    .din1 (s1_b_q),
    .dout (mul_dout)
  );

  // Unpack the per-requester operand slices.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      din0_arr[i] = bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
      din1_arr[i] = bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
    end
  end

  // Stage enables, grant qualification and next state of both pipeline stages.
  always_comb begin
    s2_en  = !out_valid_q || bus.out_ready;
    s1_en  = !s1_valid_q || s2_en;
    // Ready is forced low while reset is held, even though the flops already read idle.
    ready  = (s1_en && !ap_rst) ? grant : '0;
    accept = grant_any && s1_en && !ap_rst;

    rr_ptr_d    = rr_ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    out_valid_d = out_valid_q;
    out_dout_d  = out_dout_q;
    out_id_d    = out_id_q;

    if (s1_en) begin
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_a_d     = din0_arr[grant_id];
        s1_b_d     = din1_arr[grant_id];
        s1_id_d    = grant_id;
        rr_ptr_d   = next_ptr(grant_id);
      end else begin
        s1_valid_d = 1'b0;
      end
    end

    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_dout_d = mul_dout;
        out_id_d   = s1_id_q;
      end
    end
  end

  // Pipeline and pointer registers; reset drops any in-flight work.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_dout_q  <= '0;
      out_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_dout_q  <= out_dout_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_dout  = out_dout_q;
  assign bus.out_id    = out_id_q;
  assign busy          = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_top_fdct_mul_arbiter.sv
// Directed bench for the fdct multiplier arbiter with hand-computed products.
module tb_top_fdct_mul_arbiter;
  import top_fdct_mul_arb_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_errors;

  logic signed [63:0] exp3 [4];
  logic signed [15:0] ext_a [3];
  logic signed [12:0] ext_b [3];
  logic signed [63:0] ext_p [3];

  top_fdct_mul_arbiter_if bus ();

  top_fdct_mul_arbiter dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic signed [15:0] a,
                         input logic signed [12:0] b);
    bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH] = a;
    bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH] = b;
  endtask

  task automatic check_out(input string tag, input int id, input logic signed [63:0] p);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'sd1);
    check({tag, "_id"}, 64'(bus.out_id), 64'(id));
    check({tag, "_dout"}, 64'($signed(bus.out_dout)), p);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    exp3          = '{-64'sd100, -64'sd400, -64'sd900, -64'sd1600};
    ext_a         = '{-16'sd32768, 16'sd32767, -16'sd32768};
    ext_b         = '{-13'sd4096, -13'sd4096, 13'sd4095};
    ext_p         = '{64'sd134217728, -64'sd134213632, -64'sd134184960};
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_din0  = '0;
    bus.req_din1  = '0;
    bus.out_ready = 1'b1;

    // Reset held with all requesters asking: nothing may be granted.
    #3;
    check("rst_ready", 64'(bus.req_ready), 64'sd0);
    check("rst_busy", 64'(busy), 64'sd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'sd0);
    bus.req_valid = '0;
    step();
    rst = 1'b0;

    // Single requester 2: (1000, -7).
    step();
    set_req(2, 16'sd1000, -13'sd7);
    bus.req_valid = 4'b0100;
    #3 check("single_ready", 64'(bus.req_ready), 64'sd4);
    step();
    bus.req_valid = '0;
    #3 check("single_c1_valid", 64'(bus.out_valid), 64'sd0);
    check("single_c1_busy", 64'(busy), 64'sd1);
    step();
    #3 check_out("single_c2", 2, -64'sd7000);
    step();
    #3 check("single_c3_valid", 64'(bus.out_valid), 64'sd0);
    check("single_c3_busy", 64'(busy), 64'sd0);

    // Mid-clock reset pulse while idle: outputs must go low immediately.
    step();
    bus.req_valid = '1;
    #2 rst = 1'b1;
    #1 check("pulse_ready", 64'(bus.req_ready), 64'sd0);
    check("pulse_busy", 64'(busy), 64'sd0);
    check("pulse_out_valid", 64'(bus.out_valid), 64'sd0);
    #1 rst = 1'b0;
    bus.req_valid = '0;

    // All four requesters for 8 cycles: strict rotation, one product per cycle.
    for (int i = 0; i < 4; i++) begin
      set_req(i, 16'(100 * (i + 1)), 13'(-(i + 1)));
    end
    for (int k = 0; k < 10; k++) begin
      step();
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #3;
      if (k < 8) check($sformatf("rr_ready%0d", k), 64'(bus.req_ready), 64'(1 << (k % 4)));
      if (k >= 2) check_out($sformatf("rr_out%0d", k), (k - 2) % 4, exp3[(k - 2) % 4]);
    end

    // Backpressure with both stages full.
    step();
    set_req(0, -16'sd5, 13'sd3);
    set_req(1, 16'sd7, 13'sd11);
    bus.req_valid = 4'b0011;
    bus.out_ready = 1'b1;
    #3 check("bp_ready0", 64'(bus.req_ready), 64'sd1);
    step();
    bus.out_ready = 1'b0;
    #3 check("bp_ready1", 64'(bus.req_ready), 64'sd2);
    for (int j = 0; j < 3; j++) begin
      step();
      #3 check($sformatf("bp_hold_ready%0d", j), 64'(bus.req_ready), 64'sd0);
      check_out($sformatf("bp_hold%0d", j), 0, -64'sd15);
    end
    step();
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    #3 check_out("bp_rel0", 0, -64'sd15);
    step();
    #3 check_out("bp_rel1", 1, 64'sd77);
    step();
    #3 check("bp_drained", 64'(bus.out_valid), 64'sd0);

    // Operand extremes through requester 3, back to back.
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 3) begin
        set_req(3, ext_a[k], ext_b[k]);
        bus.req_valid = 4'b1000;
      end else begin
        bus.req_valid = '0;
      end
      #3;
      if (k < 3) check($sformatf("ext_ready%0d", k), 64'(bus.req_ready), 64'sd8);
      if (k >= 2) check_out($sformatf("ext_out%0d", k - 2), 3, ext_p[k - 2]);
    end

    // Reset with S1 and S2 full, then first grant goes to lowest valid id.
    step();
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    #3 check("mrst_ready0", 64'(bus.req_ready), 64'sd1);
    step();
    #3 check("mrst_ready1", 64'(bus.req_ready), 64'sd2);
    step();
    #3 check("mrst_full_ready", 64'(bus.req_ready), 64'sd0);
    check("mrst_full_busy", 64'(busy), 64'sd1);
    #1 rst = 1'b1;
    #1 check("mrst_out_valid", 64'(bus.out_valid), 64'sd0);
    check("mrst_busy", 64'(busy), 64'sd0);
    check("mrst_ready", 64'(bus.req_ready), 64'sd0);
    bus.req_valid = 4'b1110;
    bus.out_ready = 1'b1;
    #1 rst = 1'b0;
    #1 check("mrst_first_grant", 64'(bus.req_ready), 64'sd2);
    step();
    bus.req_valid = '0;
    #3 check("mrst_no_stale", 64'(bus.out_valid), 64'sd0);
    step();
    #3 check_out("mrst_out", 1, 64'sd77);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
